sub16_serial: RTL and testbench

Multi-cycle 16-bit subtractor computing DIFF = A − B − BI, one 4-bit nibble per clock, LSB nibble first, with a carry register between nibbles. It is the subtract counterpart of the team's 4-bit ripple adder slice. It provides a low-area ALU subtract/compare path with a start/done handshake, and it flags borrow, signed overflow and zero.

---
 rtl/sub16_serial.sv | 91 +++++++++
 tb/tb_sub16_serial.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sub16_serial.sv
// rtl/sub16_serial.sv - nibble-serial 16-bit subtractor, DIFF = A - B - BI
module sub16_serial (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        BI,
    output logic        busy,
    output logic        done,
    output logic [15:0] DIFF,
    output logic        BO,
    output logic        OFL,
    output logic        ZERO
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [1:0]  k;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] w;
    logic        c;

    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic [3:0]  s;
    logic        cout;
    logic        msb_cin;
    logic [15:0] w_next;

    // Subtraction as A + ~B + c; the carry into bit 15 is recovered from the sum bit.
    always_comb begin
        a_nib       = a_q[{k, 2'b00} +: 4];
        b_nib       = ~b_q[{k, 2'b00} +: 4];
        {cout, s}   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, c};
        msb_cin     = s[3] ^ a_nib[3] ^ b_nib[3];
        w_next      = w;
        w_next[{k, 2'b00} +: 4] = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= 2'd0;
            a_q   <= 16'd0;
            b_q   <= 16'd0;
            w     <= 16'd0;
            c     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            DIFF  <= 16'd0;
            BO    <= 1'b0;
            OFL   <= 1'b0;
            ZERO  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        c     <= ~BI;
                        k     <= 2'd0;
                        busy  <= 1'b1;
                        state <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    w <= w_next;
                    c <= cout;
                    k <= k + 2'd1;
                    if (k == 2'd3) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        DIFF  <= w_next;
                        BO    <= ~cout;
                        OFL   <= msb_cin ^ cout;
                        ZERO  <= (w_next == 16'd0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub16_serial.sv
// tb/tb_sub16_serial.sv - directed and swept checks for sub16_serial
module tb_sub16_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] A = 16'd0;
    logic [15:0] B = 16'd0;
    logic        BI = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] DIFF;
    logic        BO;
    logic        OFL;
    logic        ZERO;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    sub16_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .BI    (BI),
        .busy  (busy),
        .done  (done),
        .DIFF  (DIFF),
        .BO    (BO),
        .OFL   (OFL),
        .ZERO  (ZERO)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [15:0] ediff, input logic ebo,
                             input logic eofl, input logic ezero);
        check({tag, "_diff"}, {16'd0, DIFF}, {16'd0, ediff});
        check({tag, "_bo"},   {31'd0, BO},   {31'd0, ebo});
        check({tag, "_ofl"},  {31'd0, OFL},  {31'd0, eofl});
        check({tag, "_zero"}, {31'd0, ZERO}, {31'd0, ezero});
    endtask

    task automatic wait_done(input string tag);
        int cnt;
        cnt = 0;
        while (!done && cnt < 12) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bi,
                      input logic [15:0] ediff, input logic ebo, input logic eofl, input logic ezero);
        logic [15:0] prev;
        int cnt;
        prev = DIFF;
        @(negedge clk);
        A = a; B = b; BI = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
        check({tag, "_hold"}, {16'd0, DIFF}, {16'd0, prev});
        cnt = 0;
        while (!done && cnt < 12) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_latency"}, cnt, 32'd4);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check_res(tag, ediff, ebo, eofl, ezero);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rbi;
        logic [16:0] r;
        int          sr;
        int          t0;
        int          t1;
        int          t2;
        int          seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check_res("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        op("basic",   16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0);
        op("under",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        op("sovf",    16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        op("zero_bi", 16'h5A5A, 16'h5A59, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        op("wrap_bi", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        op("sovf_bi", 16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);

        // start re-pulsed mid-operation must be ignored
        @(negedge clk);
        A = 16'h00F0; B = 16'h000F; BI = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
        @(posedge clk); #1;
        A = 16'hFFFF; B = 16'hFFFF; BI = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign_busy", {31'd0, busy}, 32'd1);
        wait_done("ign");
        check("ign_latency", cyc - t0, 32'd4);
        check_res("ign", 16'h00E1, 1'b0, 1'b0, 1'b0);

        // asynchronous reset in the middle of an operation
        repeat (2) @(posedge clk);
        @(negedge clk);
        A = 16'h1111; B = 16'h0001; BI = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check_res("arst", 16'h0000, 1'b0, 1'b0, 1'b0);
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("arst_no_done", seen, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        op("post_rst", 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0);

        // start held high across three back-to-back operations
        @(negedge clk);
        A = 16'h7FFF; B = 16'hFFFF; BI = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        A = 16'h1000; B = 16'h0FFF; BI = 1'b1;
        wait_done("b2b0");
        t0 = cyc;
        check_res("b2b0", 16'h8000, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("b2b1_busy", {31'd0, busy}, 32'd1);
        A = 16'h8000; B = 16'h7FFF; BI = 1'b0;
        wait_done("b2b1");
        t1 = cyc;
        check_res("b2b1", 16'h0000, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("b2b2");
        t2 = cyc;
        check_res("b2b2", 16'h0001, 1'b0, 1'b1, 1'b0);
        check("b2b_gap1", t1 - t0, 32'd5);
        check("b2b_gap2", t2 - t1, 32'd5);
        @(posedge clk); #1;

        // random sweep against a behavioural model
        for (int i = 0; i < 1000; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rbi = 1'($urandom_range(0, 1));
            r   = {1'b0, ra} - {1'b0, rb} - {16'd0, rbi};
            sr  = int'($signed(ra)) - int'($signed(rb)) - int'(rbi);
            op("rand", ra, rb, rbi, r[15:0], r[16], (sr > 32767) || (sr < -32768), r[15:0] == 16'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
